clk_gen_multi: RTL and testbench



---
 rtl/clk_gen_pkg.sv | 30 +++
 rtl/clk_gen_chan.sv | 119 +++++++++++
 rtl/clk_gen_multi.sv | 63 ++++++
 tb/tb_clk_gen_multi.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the multi-channel reference-clock divider.
// The channel config is one packed word; the counters are CFG_CNT_W bits wide.
package clk_gen_pkg;

    localparam int CFG_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHASE = 2'd1,
        LOW   = 2'd2,
        HIGH  = 2'd3
    } ch_state_e;

    typedef struct packed {
        logic [CFG_CNT_W-1:0] period;
        logic [CFG_CNT_W-1:0] high;
        logic [CFG_CNT_W-1:0] phase;
        logic                 enable;
    } ch_cfg_t;

    // A halt request carries no timing, so it is never rejected.
    function automatic logic cfg_is_valid(input ch_cfg_t c);
        if (!c.enable) begin
            return 1'b1;
        end
        return (c.period >= CFG_CNT_W'(2)) && (c.high != '0) &&
               (c.high < c.period) && (c.phase < c.period);
    endfunction

endpackage

// File: rtl/clk_gen_chan.sv
// One output clock: IDLE/PHASE/LOW/HIGH FSM on a down-counter, plus a one-deep pending config slot.
// clk_out is registered; a new config is consumed from IDLE or at the last HIGH cycle only.
module clk_gen_chan
    import clk_gen_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_wr,
    input  ch_cfg_t i_cfg,
    output logic    o_pend,
    output logic    o_clk,
    output logic    o_active
);

    ch_state_e              r_state;
    ch_state_e              w_state_nxt;
    ch_cfg_t                r_pcfg;
    logic [CFG_CNT_W-1:0]   r_period;
    logic [CFG_CNT_W-1:0]   r_high;
    logic [CFG_CNT_W-1:0]   r_cnt;
    logic [CFG_CNT_W-1:0]   w_period_nxt;
    logic [CFG_CNT_W-1:0]   w_high_nxt;
    logic [CFG_CNT_W-1:0]   w_cnt_nxt;
    logic [CFG_CNT_W-1:0]   w_low_cur;
    logic [CFG_CNT_W-1:0]   w_low_new;
    logic                   r_pend;
    logic                   r_clk;
    logic                   w_consume;

    // Counter reload values are "cycles minus one" since the count ends at zero.
    assign w_low_cur = r_period - r_high - CFG_CNT_W'(1);
    assign w_low_new = r_pcfg.period - r_pcfg.high - CFG_CNT_W'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt - CFG_CNT_W'(1);
        w_period_nxt = r_period;
        w_high_nxt   = r_high;
        w_consume    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = r_cnt;
                if (r_pend) begin
                    w_consume = 1'b1;
                    if (r_pcfg.enable) begin
                        w_period_nxt = r_pcfg.period;
                        w_high_nxt   = r_pcfg.high;
                        if (r_pcfg.phase != '0) begin
                            w_state_nxt = PHASE;
                            w_cnt_nxt   = r_pcfg.phase - CFG_CNT_W'(1);
                        end else begin
                            w_state_nxt = LOW;
                            w_cnt_nxt   = w_low_new;
                        end
                    end
                end
            end
            PHASE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = w_low_cur;
                end
            end
            LOW: begin
                if (r_cnt == '0) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = r_high - CFG_CNT_W'(1);
                end
            end
            default: begin
                // Last HIGH cycle is the period boundary: the only safe point to retune or halt.
                if (r_cnt == '0) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = w_low_cur;
                    if (r_pend) begin
                        w_consume = 1'b1;
                        if (r_pcfg.enable) begin
                            w_period_nxt = r_pcfg.period;
                            w_high_nxt   = r_pcfg.high;
                            w_cnt_nxt    = w_low_new;
                        end else begin
                            w_state_nxt = IDLE;
                            w_cnt_nxt   = '0;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_period <= '0;
            r_high   <= '0;
            r_pcfg   <= '0;
            r_pend   <= 1'b0;
            r_clk    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_period <= w_period_nxt;
            r_high   <= w_high_nxt;
            r_clk    <= (w_state_nxt == HIGH);
            if (i_wr) begin
                r_pend <= 1'b1;
                r_pcfg <= i_cfg;
            end else if (w_consume) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_pend   = r_pend;
    assign o_clk    = r_clk;
    assign o_active = (r_state != IDLE);

endmodule

// File: rtl/clk_gen_multi.sv
// NUM_CH programmable clocks from one reference; shared config decode/validation feeds per-channel slots.
// cfg_ready drops while the addressed channel still holds an unconsumed config; cfg_err pulses one cycle after a rejected accept.
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  CNT_W  = CFG_CNT_W,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_phase,
    input  logic              cfg_enable,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] ch_active
);

    ch_cfg_t           w_cfg;
    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_wr;
    logic              w_ch_ok;
    logic              w_accept;
    logic              w_good;
    logic              r_err;

    assign w_cfg    = '{period: cfg_period, high: cfg_high, phase: cfg_phase, enable: cfg_enable};
    assign w_ch_ok  = (int'(cfg_ch) < NUM_CH);
    // An out-of-range channel has no slot, so it is always accepted and then rejected.
    assign cfg_ready = !rst && !(w_ch_ok && w_pend[cfg_ch]);
    assign w_accept  = cfg_valid && cfg_ready;
    assign w_good    = w_ch_ok && cfg_is_valid(w_cfg);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && !w_good;
        end
    end

    assign cfg_err = r_err;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_wr[i] = w_accept && w_good && (cfg_ch == CH_W'(i));

        clk_gen_chan u_chan (
            .clk      (clk),
            .rst      (rst),
            .i_wr     (w_wr[i]),
            .i_cfg    (w_cfg),
            .o_pend   (w_pend[i]),
            .o_clk    (clk_out[i]),
            .o_active (ch_active[i])
        );
    end

endmodule

// File: tb/tb_clk_gen_multi.sv
// Scoreboarded bench: a per-channel waveform model queues expected bits, a monitor pops and compares.
// Three channels leave cfg_ch = 3 free to exercise the out-of-range reject.
module tb_clk_gen_multi;

    localparam int NCH = 3;
    localparam int CW  = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_enable = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [CW-1:0]  cfg_period = '0;
    logic [CW-1:0]  cfg_high = '0;
    logic [CW-1:0]  cfg_phase = '0;
    logic           cfg_ready;
    logic           cfg_err;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] ch_active;

    int vectors = 0;
    int miscompares = 0;

    clk_gen_multi #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_phase  (cfg_phase),
        .cfg_enable (cfg_enable),
        .cfg_err    (cfg_err),
        .clk_out    (clk_out),
        .ch_active  (ch_active)
    );

    always #5 clk = ~clk;

    typedef struct { int p; int h; int ph; bit en; } mcfg_t;
    typedef struct { logic [NCH-1:0] clk; logic [NCH-1:0] act; logic err; } exp_t;

    mcfg_t m_cur  [NCH];
    mcfg_t m_pcfg [NCH];
    bit    m_act  [NCH];
    bit    m_pend [NCH];
    bit    m_wave [NCH][$];
    exp_t  oq[$];
    bit    rq[$];

    bit    s_rst = 1'b1;
    bit    s_acc = 1'b0;
    int    s_ch  = 0;
    mcfg_t s_cfg;

    function automatic bit cfg_ok(input mcfg_t c);
        return !c.en || (c.p >= 2 && c.h >= 1 && c.h <= c.p - 1 && c.ph < c.p);
    endfunction

    // One full period of expected output bits, optionally preceded by the start delay.
    function automatic void fill(input int c, input bit with_phase);
        if (with_phase) repeat (m_cur[c].ph) m_wave[c].push_back(1'b0);
        repeat (m_cur[c].p - m_cur[c].h) m_wave[c].push_back(1'b0);
        repeat (m_cur[c].h) m_wave[c].push_back(1'b1);
    endfunction

    function automatic void model_edge();
        exp_t e;
        e.clk = '0;
        e.act = '0;
        e.err = 1'b0;
        if (s_rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_act[c]  = 1'b0;
                m_pend[c] = 1'b0;
                m_wave[c].delete();
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (m_act[c]) begin
                    if (m_wave[c].size() == 0) begin
                        if (m_pend[c]) begin
                            m_pend[c] = 1'b0;
                            if (m_pcfg[c].en) begin
                                m_cur[c] = m_pcfg[c];
                                fill(c, 1'b0);
                            end else begin
                                m_act[c] = 1'b0;
                            end
                        end else begin
                            fill(c, 1'b0);
                        end
                    end
                end else if (m_pend[c]) begin
                    m_pend[c] = 1'b0;
                    if (m_pcfg[c].en) begin
                        m_cur[c] = m_pcfg[c];
                        m_act[c] = 1'b1;
                        fill(c, 1'b1);
                    end
                end
                if (m_act[c]) begin
                    e.act[c] = 1'b1;
                    e.clk[c] = m_wave[c].pop_front();
                end
            end
            if (s_acc) begin
                if (s_ch < NCH && cfg_ok(s_cfg)) begin
                    m_pend[s_ch] = 1'b1;
                    m_pcfg[s_ch] = s_cfg;
                end else begin
                    e.err = 1'b1;
                end
            end
        end
        oq.push_back(e);
    endfunction

    // Model: advance at each edge, then snapshot the inputs that the next edge will see.
    initial begin : model
        bit exp_ready;
        forever begin
            @(posedge clk);
            #1;
            model_edge();
            @(negedge clk);
            #2;
            s_rst = rst;
            s_ch  = int'(cfg_ch);
            s_cfg = '{p: int'(cfg_period), h: int'(cfg_high), ph: int'(cfg_phase), en: cfg_enable};
            exp_ready = !rst && (s_ch >= NCH || !m_pend[s_ch]);
            s_acc = cfg_valid && exp_ready;
            rq.push_back(exp_ready);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        bit   r;
        forever begin
            @(posedge clk);
            #2;
            if (oq.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_outputs at %0t: no expectation queued", $time);
            end else begin
                e = oq.pop_front();
                chk("clk_out",   32'(clk_out),   32'(e.clk));
                chk("ch_active", 32'(ch_active), 32'(e.act));
                chk("cfg_err",   32'(cfg_err),   32'(e.err));
            end
            @(negedge clk);
            #3;
            if (rq.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_ready at %0t: no expectation queued", $time);
            end else begin
                r = rq.pop_front();
                chk("cfg_ready", 32'(cfg_ready), 32'(r));
            end
        end
    end

    // Called at a falling edge; holds the request until the DUT is ready and one edge accepts it.
    task automatic cfg_write(input int ch, input int p, input int h, input int ph, input bit en);
        int n;
        n = 0;
        cfg_valid  = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_period = CW'(p);
        cfg_high   = CW'(h);
        cfg_phase  = CW'(ph);
        cfg_enable = en;
        #3;
        while (!cfg_ready && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (n >= 200) begin
            miscompares++;
            $display("FAIL cfg_write_timeout ch%0d: ready never rose within 200 cycles", ch);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic cfg_try(input int ch, input int p, input int h, input int ph, input bit en);
        cfg_valid  = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_period = CW'(p);
        cfg_high   = CW'(h);
        cfg_phase  = CW'(ph);
        cfg_enable = en;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_out(input int c, input logic v);
        int n;
        n = 0;
        while (clk_out[c] !== v && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 100) begin
            miscompares++;
            $display("FAIL wait_clk_out%0d: got %b, expected %b within 100 cycles", c, clk_out[c], v);
        end
    endtask

    initial begin : stimulus
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        cfg_write(0, 4, 2, 0, 1'b1);
        cfg_write(1, 5, 1, 3, 1'b1);
        repeat (12) @(negedge clk);

        // Retune ch0 mid-LOW, probe the busy slot, then load ch2 in the same window.
        wait_out(0, 1'b1);
        wait_out(0, 1'b0);
        cfg_write(0, 6, 3, 0, 1'b1);
        cfg_try(0, 7, 2, 0, 1'b1);
        cfg_write(2, 3, 1, 1, 1'b1);
        repeat (15) @(negedge clk);

        cfg_write(1, 5, 0, 0, 1'b1);
        cfg_write(1, 1, 1, 0, 1'b1);
        cfg_write(3, 4, 2, 0, 1'b1);
        repeat (8) @(negedge clk);

        wait_out(0, 1'b1);
        cfg_write(0, 0, 0, 0, 1'b0);
        repeat (20) @(negedge clk);

        wait_out(1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            int ch;
            int p;
            int h;
            int ph;
            bit en;
            ch = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
            p  = int'($urandom_range(1, 9));
            h  = int'($urandom_range(0, p));
            ph = int'($urandom_range(0, p));
            en = ($urandom_range(0, 9) != 0);
            cfg_write(ch, p, h, ph, en);
            repeat ($urandom_range(0, 6)) @(negedge clk);
            if (i == 150) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        end

        repeat (30) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
